apb_timer_slave: RTL and testbench

APB peripheral that sits directly downstream of the AHB-to-APB bridge. It decodes one bit of the bridge's 3-bit PSELx bus, services APB write and read transfers into a four-register bank, and returns read data on PRDATA toward the bridge's HRDATA path. The block contains a prescaled 32-bit down-counter timer with auto-reload, a sticky expiry flag and an interrupt output. It inserts no wait states; the bridge has no PREADY input, so every transfer completes in the standard two-cycle setup/access sequence.

---
 rtl/apb_timer_slave.sv | 138 +++++++++++++
 tb/tb_apb_timer_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_slave
// Description : APB slave with a four-register bank and a prescaled 32-bit
//               auto-reload down-counter timer with sticky expiry and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timer_slave #(
    parameter int SLOT = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [2:0]  PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        TIMER_IRQ
);

    localparam logic [1:0] c_slot        = 2'(SLOT);
    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_load   = 2'd1;
    localparam logic [1:0] c_addr_count  = 2'd2;
    localparam logic [1:0] c_addr_status = 2'd3;

    logic        r_en;
    logic        r_reload;
    logic        r_irq_en;
    logic [7:0]  r_prescale;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_expired;
    logic [7:0]  r_ps;

    logic        w_sel;
    logic        w_wr;
    logic [1:0]  w_addr;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_expire;
    logic        w_unused_bits;

    assign w_sel       = PSELx[c_slot];
    assign w_wr        = w_sel & PENABLE & PWRITE;
    assign w_addr      = PADDR[3:2];
    assign w_wr_ctrl   = w_wr && (w_addr == c_addr_ctrl);
    assign w_wr_load   = w_wr && (w_addr == c_addr_load);
    assign w_wr_count  = w_wr && (w_addr == c_addr_count);
    assign w_wr_status = w_wr && (w_addr == c_addr_status);

    assign w_tick   = r_en && (r_ps == r_prescale);
    // A direct COUNT write overrides the tick, so it also suppresses expiry.
    assign w_expire = w_tick && (r_count == '0) && !w_wr_count;

    assign w_unused_bits = ^{PADDR[31:4], PADDR[1:0], PSELx};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_en       <= 1'b0;
            r_reload   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= 8'd0;
        end else if (w_wr_ctrl) begin
            r_en       <= PWDATA[0];
            r_reload   <= PWDATA[1];
            r_irq_en   <= PWDATA[2];
            r_prescale <= PWDATA[15:8];
        end else if (w_expire && !r_reload) begin
            r_en <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_load <= 32'd0;
        end else if (w_wr_load) begin
            r_load <= PWDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_count <= 32'd0;
        end else if (w_wr_count) begin
            r_count <= PWDATA;
        end else if (w_tick) begin
            if (r_count != '0) begin
                r_count <= r_count - 32'd1;
            end else if (r_reload) begin
                r_count <= r_load;
            end
        end
    end

    // Expiry set takes priority over a simultaneous write-one-to-clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_status && PWDATA[0]) begin
            r_expired <= 1'b0;
        end
    end

    // PS is not reset by a PRESCALE change; a stale PS above the new compare
    // value wraps through 255 before matching.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ps <= 8'd0;
        end else if (!r_en || w_tick) begin
            r_ps <= 8'd0;
        end else begin
            r_ps <= r_ps + 8'd1;
        end
    end

    always_comb begin
        PRDATA = 32'd0;
        if (w_sel && !PWRITE) begin
            case (w_addr)
                c_addr_ctrl:   PRDATA = {16'd0, r_prescale, 5'd0, r_irq_en, r_reload, r_en};
                c_addr_load:   PRDATA = r_load;
                c_addr_count:  PRDATA = r_count;
                default:       PRDATA = {31'd0, r_expired};
            endcase
        end
    end

    assign TIMER_IRQ = r_expired & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_timer_slave
// Description : Directed and randomized bench for apb_timer_slave with a
//               cycle-level reference model of the register/timer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_timer_slave;

    localparam int         SLOT    = 1;
    localparam logic [2:0] C_SEL   = 3'(1 << SLOT);
    localparam logic [2:0] C_OTHER = 3'(1 << ((SLOT + 1) % 3));

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [2:0]  PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        TIMER_IRQ;

    int checks = 0;
    int errors = 0;

    // Reference state: CTRL kept as its masked 32-bit register image.
    logic [31:0] m_ctrl, m_load, m_count;
    logic        m_expired;
    int          m_ps;

    apb_timer_slave #(.SLOT(SLOT)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .TIMER_IRQ (TIMER_IRQ)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK or negedge HRESETn) begin : model_blk
        logic       wr, tick, expire, en;
        logic [1:0] idx;
        int         pre;
        if (!HRESETn) begin
            m_ctrl = 0; m_load = 0; m_count = 0; m_expired = 0; m_ps = 0;
        end else begin
            wr     = PSELx[SLOT] && PENABLE && PWRITE;
            idx    = PADDR[3:2];
            en     = m_ctrl[0];
            pre    = int'(m_ctrl[15:8]);
            tick   = en && (m_ps == pre);
            expire = tick && (m_count == 0) && !(wr && idx == 2);
            m_ps   = (!en || tick) ? 0 : (m_ps + 1) % 256;
            if (wr && idx == 2)
                m_count = PWDATA;
            else if (tick)
                m_count = (m_count > 0) ? m_count - 1 : (m_ctrl[1] ? m_load : 32'd0);
            if (expire)
                m_expired = 1'b1;
            else if (wr && idx == 3 && PWDATA[0])
                m_expired = 1'b0;
            if (expire && !m_ctrl[1])
                m_ctrl[0] = 1'b0;
            if (wr && idx == 0)
                m_ctrl = PWDATA & 32'h0000_FF07;
            if (wr && idx == 1)
                m_load = PWDATA;
        end
    end

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return m_ctrl;
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {31'd0, m_expired};
        endcase
    endfunction

    function automatic logic [31:0] model_irq();
        return {31'd0, m_expired & m_ctrl[2]};
    endfunction

    function automatic logic [31:0] mkaddr(input logic [1:0] idx);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = idx;
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        PSELx = 3'd0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd0; PWDATA = 32'd0;
    endtask

    task automatic apb_write(input logic [1:0] idx, input logic [31:0] data);
        @(posedge HCLK); #1;
        PSELx = C_SEL; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = mkaddr(idx); PWDATA = data;
        @(posedge HCLK); #1;
        PENABLE = 1'b1; PADDR = mkaddr(idx);
        @(posedge HCLK); #1;
        idle();
    endtask

    task automatic apb_read(input logic [1:0] idx, output logic [31:0] data);
        @(posedge HCLK); #1;
        PSELx = C_SEL; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = mkaddr(idx);
        @(negedge HCLK);
        data = PRDATA;
        check("rd_setup", PRDATA, model_read(idx));
        check("irq", {31'd0, TIMER_IRQ}, model_irq());
        @(posedge HCLK); #1;
        PENABLE = 1'b1; PADDR = mkaddr(idx);
        @(negedge HCLK);
        check("rd_access", PRDATA, model_read(idx));
        @(posedge HCLK); #1;
        idle();
    endtask

    // Transfer addressed to a different slave: must be ignored and read as 0.
    task automatic apb_other(input logic wr, input logic [1:0] idx, input logic [31:0] data);
        @(posedge HCLK); #1;
        PSELx = C_OTHER; PWRITE = wr; PENABLE = 1'b0; PADDR = mkaddr(idx); PWDATA = data;
        @(negedge HCLK);
        check("other_setup", PRDATA, 32'd0);
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(negedge HCLK);
        check("other_access", PRDATA, 32'd0);
        @(posedge HCLK); #1;
        idle();
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  idx;
        int          r;
        idle();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Load some state, then reset in the middle of a LOAD write.
        apb_write(2'd1, 32'h1234_5678);
        apb_write(2'd2, 32'h0000_0040);
        apb_write(2'd0, 32'h0000_0105);
        @(posedge HCLK); #1;
        PSELx = C_SEL; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = mkaddr(2'd1); PWDATA = 32'hFFFF_FFFF;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        #3 HRESETn = 1'b0;
        @(posedge HCLK); #1;
        idle();
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        check("reset_irq", {31'd0, TIMER_IRQ}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            apb_read(2'(i), d);
            check("reset_reg", d, 32'd0);
        end

        // Register access with junk in the undecoded address bits.
        apb_write(2'd1, 32'hDEAD_BEEF);
        apb_read(2'd1, d);
        check("load_readback", d, 32'hDEAD_BEEF);
        apb_other(1'b0, 2'd1, 32'd0);
        apb_other(1'b1, 2'd1, 32'h5555_5555);
        apb_read(2'd1, d);
        check("load_after_other", d, 32'hDEAD_BEEF);
        apb_write(2'd0, 32'hFFFF_FFFF);
        apb_read(2'd0, d);
        check("ctrl_mask", d, 32'h0000_FF07);
        apb_write(2'd0, 32'd0);

        // One-shot: expiry on the 4th edge after the CTRL write.
        apb_write(2'd3, 32'd1);
        apb_write(2'd2, 32'd3);
        apb_write(2'd0, 32'h0000_0005);
        for (int k = 1; k <= 4; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            check("oneshot_irq", {31'd0, TIMER_IRQ}, 32'(k == 4));
        end
        apb_read(2'd0, d);
        check("oneshot_ctrl", d, 32'h0000_0004);
        apb_read(2'd2, d);
        check("oneshot_count", d, 32'd0);

        // Auto-reload, PRESCALE=2: count steps every 3 cycles, period 9.
        apb_write(2'd3, 32'd1);
        apb_write(2'd1, 32'd2);
        apb_write(2'd2, 32'd2);
        apb_write(2'd0, 32'h0000_0203);
        PSELx = C_SEL; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = mkaddr(2'd2);
        for (int k = 0; k < 27; k++) begin
            if (k > 0) @(posedge HCLK);
            @(negedge HCLK);
            check("reload_count", PRDATA, 32'(2 - ((k / 3) % 3)));
            check("reload_model", PRDATA, model_read(2'd2));
        end
        // Expiries land at write edge +27 and +36; aim the W1C at +36.
        apb_write(2'd3, 32'd1);
        apb_read(2'd3, d);
        check("w1c_cleared", d, 32'd0);
        @(posedge HCLK);
        apb_write(2'd3, 32'd1);
        apb_read(2'd3, d);
        check("w1c_vs_expiry", d, 32'd1);
        // Clear, then write COUNT on the next zero-count tick (edge +45).
        apb_write(2'd3, 32'd1);
        apb_write(2'd2, 32'h0000_0010);
        apb_read(2'd2, d);
        check("count_wr_vs_tick", d, 32'h0000_0010);
        apb_read(2'd3, d);
        check("count_wr_no_expiry", d, 32'd0);
        apb_write(2'd0, 32'd0);

        // IRQ clear: W0 has no effect, W1 drops IRQ the next cycle.
        apb_write(2'd3, 32'd1);
        apb_write(2'd2, 32'd0);
        apb_write(2'd0, 32'h0000_0005);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("irq_set", {31'd0, TIMER_IRQ}, 32'd1);
        apb_write(2'd3, 32'd0);
        @(negedge HCLK);
        check("irq_w0", {31'd0, TIMER_IRQ}, 32'd1);
        apb_write(2'd3, 32'd1);
        @(negedge HCLK);
        check("irq_w1c", {31'd0, TIMER_IRQ}, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            r   = int'($urandom_range(0, 9));
            idx = 2'($urandom_range(0, 3));
            if (r < 4) begin
                d = $urandom;
                if (idx == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
                else if (idx != 2'd3) d = 32'($urandom_range(0, 12));
                apb_write(idx, d);
            end else if (r < 8) begin
                apb_read(idx, d);
            end else if (r == 8) begin
                apb_other(1'($urandom_range(0, 1)), idx, $urandom);
            end else begin
                repeat (int'($urandom_range(1, 5))) @(posedge HCLK);
                @(negedge HCLK);
                check("idle_irq", {31'd0, TIMER_IRQ}, model_irq());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
